// File: rtl/object_patrol_move_pkg.sv
// mover_pkg: shared boundary-mode and FSM state types for the patrol mover
package mover_pkg;
  typedef enum logic [1:0] {STOP = 2'd0, WRAP = 2'd1, BOUNCE = 2'd2} mode_t;
  typedef enum logic [1:0] {MOVING = 2'd0, DWELL = 2'd1, HALTED = 2'd2} mover_state_t;
  localparam int FRAC_BITS_DEFAULT = 6;
endpackage

// File: rtl/object_patrol_move_if.sv
// object_patrol_move_if: frame/control inputs and sprite position outputs of the mover
interface object_patrol_move_if;
  logic startOfFrame;
  logic enable;
  logic restart;
  logic [1:0] mode;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic dirX;
  logic dirY;
  logic edgeHit;
  logic halted;
  modport master(output startOfFrame, enable, restart, mode,
                 input topLeftX, topLeftY, dirX, dirY, edgeHit, halted);
  modport slave(input startOfFrame, enable, restart, mode,
                output topLeftX, topLeftY, dirX, dirY, edgeHit, halted);
endinterface

// File: rtl/object_patrol_move_axis_step.sv
// axis_step: one-axis candidate position and boundary detection for a single frame step
module axis_step
  import mover_pkg::*;
(
  input  logic signed [31:0] pos_i,
  input  logic signed [31:0] vel_i,
  input  logic signed [31:0] min_i,
  input  logic signed [31:0] max_i,
  input  logic [1:0]         mode_i,
  output logic signed [31:0] nxt_o,
  output logic               over_o,
  output logic               under_o,
  output logic               flip_o
);
  logic signed [31:0] sum;
  assign sum     = pos_i + vel_i;
  assign over_o  = sum > max_i;
  assign under_o = sum < min_i;
  assign flip_o  = (over_o || under_o) && mode_i == BOUNCE;
  // anything that is not WRAP clamps the offending axis
  assign nxt_o = over_o  ? (mode_i == WRAP ? min_i + (sum - max_i) : max_i) :
                 under_o ? (mode_i == WRAP ? max_i - (min_i - sum) : min_i) : sum;
endmodule

// File: rtl/object_patrol_move.sv
// object_patrol_move: per-frame two-axis fixed-point sprite mover with stop/wrap/bounce edges
module object_patrol_move
  import mover_pkg::*;
#(
  parameter int FRAC_BITS    = FRAC_BITS_DEFAULT,
  parameter int INITIAL_X    = 280,
  parameter int INITIAL_Y    = 100,
  parameter int X_SPEED      = 30,
  parameter int Y_SPEED      = 0,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 600,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 440,
  parameter int DWELL_FRAMES = 15
) (
  input logic clk,
  input logic reset,
  object_patrol_move_if.slave bus
);
  localparam logic signed [31:0] X_MIN_F  = X_MIN << FRAC_BITS;
  localparam logic signed [31:0] X_MAX_F  = X_MAX << FRAC_BITS;
  localparam logic signed [31:0] Y_MIN_F  = Y_MIN << FRAC_BITS;
  localparam logic signed [31:0] Y_MAX_F  = Y_MAX << FRAC_BITS;
  localparam logic signed [31:0] X_INIT_F = INITIAL_X << FRAC_BITS;
  localparam logic signed [31:0] Y_INIT_F = INITIAL_Y << FRAC_BITS;
  mover_state_t state_q, state_d;
  logic signed [31:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [31:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [31:0] cnt_q, cnt_d;
  logic flip_x_q, flip_x_d, flip_y_q, flip_y_d;
  logic edge_q, edge_d;
  logic signed [31:0] nxt_x, nxt_y;
  logic over_x, under_x, fx, over_y, under_y, fy;
  logic frame, hit;
  axis_step u_x (
    .pos_i(pos_x_q), .vel_i(vel_x_q), .min_i(X_MIN_F), .max_i(X_MAX_F), .mode_i(bus.mode),
    .nxt_o(nxt_x), .over_o(over_x), .under_o(under_x), .flip_o(fx)
  );
  axis_step u_y (
    .pos_i(pos_y_q), .vel_i(vel_y_q), .min_i(Y_MIN_F), .max_i(Y_MAX_F), .mode_i(bus.mode),
    .nxt_o(nxt_y), .over_o(over_y), .under_o(under_y), .flip_o(fy)
  );
  assign frame = bus.startOfFrame && bus.enable;
  assign hit   = over_x || under_x || over_y || under_y;
  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    vel_x_d  = vel_x_q;
    vel_y_d  = vel_y_q;
    cnt_d    = cnt_q;
    flip_x_d = flip_x_q;
    flip_y_d = flip_y_q;
    edge_d   = 1'b0;
    if (frame && state_q == MOVING) begin
      pos_x_d = nxt_x;
      pos_y_d = nxt_y;
      edge_d  = hit;
      if (hit && bus.mode == BOUNCE) begin
        if (DWELL_FRAMES == 0) begin
          vel_x_d = fx ? -vel_x_q : vel_x_q;
          vel_y_d = fy ? -vel_y_q : vel_y_q;
        end else begin
          flip_x_d = fx;
          flip_y_d = fy;
          cnt_d    = 32'(DWELL_FRAMES);
          state_d  = DWELL;
        end
      end else if (hit && bus.mode != WRAP) state_d = HALTED;
    end else if (frame && state_q == DWELL) begin
      // the reversal frame itself carries no motion
      if (cnt_q != 0) cnt_d = cnt_q - 1;
      else begin
        vel_x_d  = flip_x_q ? -vel_x_q : vel_x_q;
        vel_y_d  = flip_y_q ? -vel_y_q : vel_y_q;
        flip_x_d = 1'b0;
        flip_y_d = 1'b0;
        state_d  = MOVING;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset || bus.restart) begin
      state_q  <= MOVING;
      pos_x_q  <= X_INIT_F;
      pos_y_q  <= Y_INIT_F;
      vel_x_q  <= X_SPEED;
      vel_y_q  <= Y_SPEED;
      cnt_q    <= '0;
      flip_x_q <= 1'b0;
      flip_y_q <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      vel_x_q  <= vel_x_d;
      vel_y_q  <= vel_y_d;
      cnt_q    <= cnt_d;
      flip_x_q <= flip_x_d;
      flip_y_q <= flip_y_d;
      edge_q   <= edge_d;
    end
  end
  assign bus.topLeftX = 11'(pos_x_q >>> FRAC_BITS);
  assign bus.topLeftY = 11'(pos_y_q >>> FRAC_BITS);
  assign bus.dirX     = vel_x_q[31];
  assign bus.dirY     = vel_y_q[31];
  assign bus.edgeHit  = edge_q;
  assign bus.halted   = state_q == HALTED;
endmodule

// File: tb/tb_object_patrol_move.sv
// tb_object_patrol_move: three mover configurations against a frame-level reference model
module tb_object_patrol_move;
  localparam int IX[3]  = '{280, 280, 300};
  localparam int IY[3]  = '{100, 100, 100};
  localparam int VX[3]  = '{30, 64, 64};
  localparam int VY[3]  = '{0, -40, 25};
  localparam int XMN[3] = '{0, 0, 0};
  localparam int XMX[3] = '{600, 282, 300};
  localparam int YMN[3] = '{0, 95, 80};
  localparam int YMX[3] = '{440, 110, 120};
  localparam int DW[3]  = '{15, 15, 0};
  localparam int MV = 0, DWS = 1, HLT = 2;
  logic clk, rst, sof, en, rs;
  logic [1:0] md[3];
  logic signed [10:0] tlx[3], tly[3];
  logic dx[3], dy[3], eh[3], hl[3];
  longint p[3][2], v[3][2];
  bit fl[3][2];
  int st[3], cnt[3];
  bit me[3];
  bit chk_on = 0;
  int n_chk = 0, n_fail = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    object_patrol_move_if b ();
    object_patrol_move #(
      .FRAC_BITS(6), .INITIAL_X(IX[g]), .INITIAL_Y(IY[g]), .X_SPEED(VX[g]), .Y_SPEED(VY[g]),
      .X_MIN(XMN[g]), .X_MAX(XMX[g]), .Y_MIN(YMN[g]), .Y_MAX(YMX[g]), .DWELL_FRAMES(DW[g])
    ) u (.clk(clk), .reset(rst), .bus(b));
    assign b.startOfFrame = sof;
    assign b.enable       = en;
    assign b.restart      = rs;
    assign b.mode         = md[g];
    assign tlx[g] = b.topLeftX;
    assign tly[g] = b.topLeftY;
    assign dx[g]  = b.dirX;
    assign dy[g]  = b.dirY;
    assign eh[g]  = b.edgeHit;
    assign hl[g]  = b.halted;
  end
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic longint lim(int d, int a, bit top);
    return 64 * longint'(a == 0 ? (top ? XMX[d] : XMN[d]) : (top ? YMX[d] : YMN[d]));
  endfunction
  // one frame of the reference: whole-frame semantics on plain integers
  function automatic void mstep(int d);
    longint n;
    bit hit = 0;
    bit off[2] = '{0, 0};
    me[d] = 0;
    if (rst || rs) begin
      p[d][0] = 64 * longint'(IX[d]);
      p[d][1] = 64 * longint'(IY[d]);
      v[d][0] = VX[d];
      v[d][1] = VY[d];
      st[d] = MV;
      cnt[d] = 0;
      fl[d] = '{0, 0};
      return;
    end
    if (!(sof && en) || st[d] == HLT) return;
    if (st[d] == DWS) begin
      if (cnt[d] > 0) cnt[d]--;
      else begin
        for (int a = 0; a < 2; a++) if (fl[d][a]) v[d][a] = -v[d][a];
        fl[d] = '{0, 0};
        st[d] = MV;
      end
      return;
    end
    for (int a = 0; a < 2; a++) begin
      n = p[d][a] + v[d][a];
      if (n > lim(d, a, 1)) p[d][a] = md[d] == 1 ? lim(d, a, 0) + (n - lim(d, a, 1)) : lim(d, a, 1);
      else if (n < lim(d, a, 0)) p[d][a] = md[d] == 1 ? lim(d, a, 1) - (lim(d, a, 0) - n) : lim(d, a, 0);
      else p[d][a] = n;
      off[a] = n > lim(d, a, 1) || n < lim(d, a, 0);
      hit |= off[a];
    end
    me[d] = hit;
    if (!hit || md[d] == 1) return;
    if (md[d] != 2) begin
      st[d] = HLT;
      return;
    end
    for (int a = 0; a < 2; a++) if (off[a]) begin
      if (DW[d] == 0) v[d][a] = -v[d][a];
      else fl[d][a] = 1;
    end
    if (DW[d] != 0) begin
      cnt[d] = DW[d];
      st[d] = DWS;
    end
  endfunction
  always @(posedge clk) for (int d = 0; d < 3; d++) mstep(d);
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (chk_on) for (int d = 0; d < 3; d++) begin
    chk($sformatf("d%0d_topLeftX", d), int'(tlx[d]), int'(p[d][0] >>> 6));
    chk($sformatf("d%0d_topLeftY", d), int'(tly[d]), int'(p[d][1] >>> 6));
    chk($sformatf("d%0d_dirX", d), int'(dx[d]), int'(v[d][0] < 0));
    chk($sformatf("d%0d_dirY", d), int'(dy[d]), int'(v[d][1] < 0));
    chk($sformatf("d%0d_edgeHit", d), int'(eh[d]), int'(me[d]));
    chk($sformatf("d%0d_halted", d), int'(hl[d]), int'(st[d] == HLT));
  end
  task automatic pin(string nm, int d, int a, int exp);
    chk({nm, "_dut"}, a != 0 ? int'(tly[d]) : int'(tlx[d]), exp);
    chk({nm, "_model"}, int'(p[d][a] >>> 6), exp);
  endtask
  task automatic cyc(bit s, bit r = 0, bit x = 0);
    sof = s;
    rs  = r;
    rst = x;
    @(negedge clk);
    sof = 0;
    rs  = 0;
    rst = 0;
  endtask
  task automatic frame(int k = 1);
    repeat (k) begin
      cyc(0);
      cyc(1);
    end
  endtask
  initial begin
    rst = 1;
    sof = 0;
    en = 1;
    rs = 0;
    md = '{2'd2, 2'd2, 2'd1};
    @(negedge clk);
    chk_on = 1;
    cyc(0, 0, 1);
    pin("rst_x", 0, 0, 280);
    pin("rst_y", 0, 1, 100);
    chk("rst_halted", int'(hl[0]), 0);
    frame();
    pin("def_f1_x", 0, 0, 280);
    pin("b_f1_x", 1, 0, 281);
    pin("wrap_x", 2, 0, 1);
    chk("wrap_edge", int'(eh[2]), 1);
    chk("wrap_halted", int'(hl[2]), 0);
    frame();
    pin("b_f2_x", 1, 0, 282);
    frame();
    pin("def_f3_x", 0, 0, 281);
    pin("b_f3_x", 1, 0, 282);
    chk("b_f3_edge", int'(eh[1]), 1);
    frame(15);
    pin("b_dwell_x", 1, 0, 282);
    chk("b_dwell_dir", int'(dx[1]), 0);
    frame();
    pin("b_rev_x", 1, 0, 282);
    chk("b_rev_dir", int'(dx[1]), 1);
    frame();
    pin("b_back_x", 1, 0, 281);
    frame(44);
    pin("def_f64_x", 0, 0, 310);
    pin("def_f64_y", 0, 1, 100);
    cyc(1, 1);
    pin("rs_sof_x", 0, 0, 280);
    chk("rs_sof_pos", int'(p[0][0]), 17920);
    pin("rs_sof_x2", 2, 0, 300);
    md[2] = 2'd0;
    frame();
    pin("stop_x", 2, 0, 300);
    chk("stop_halted", int'(hl[2]), 1);
    chk("stop_edge", int'(eh[2]), 1);
    frame(10);
    pin("stop_hold_x", 2, 0, 300);
    cyc(0, 1);
    pin("stop_rs_x", 2, 0, 300);
    chk("stop_rs_halted", int'(hl[2]), 0);
    en = 0;
    frame(20);
    pin("dis_x0", 0, 0, 280);
    pin("dis_x1", 1, 0, 280);
    en = 1;
    frame(3);
    pin("en_x0", 0, 0, 281);
    frame(5);
    cyc(0, 0, 1);
    pin("mid_rst_x", 1, 0, 280);
    chk("mid_rst_dir", int'(dx[1]), 0);
    chk("mid_rst_halted", int'(hl[1]), 0);
    frame();
    pin("mid_rst_f1", 1, 0, 281);
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) for (int d = 0; d < 3; d++) md[d] = 2'($urandom_range(0, 3));
      en = $urandom_range(0, 7) != 0;
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 79) == 0, $urandom_range(0, 299) == 0);
    end
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/object_patrol_move.md
# object_patrol_move

Parametrised two-axis mover for sprite objects (ropes, vines, platforms, enemies) in the VGA game layer. It holds a fixed-point top-left position and advances it once per frame on `startOfFrame`. It applies a per-axis boundary policy (stop, wrap or bounce with a dwell pause) and drives the integer `topLeftX`/`topLeftY` consumed by the object's bitmap/draw block. It generalises the single-axis constant-speed mover with Y motion, bounds, runtime mode, enable/restart control and edge reporting.

## Interface
- `FRAC_BITS`, 6: fixed-point fraction bits (multiplier 64).
- `INITIAL_X`, 280: reset/restart X, in pixels.
- `INITIAL_Y`, 100: reset/restart Y, in pixels.
- `X_SPEED`, 30: signed X velocity, in fixed-point units per frame.
- `Y_SPEED`, 0: signed Y velocity, in fixed-point units per frame.
- `X_MIN`, 0: inclusive X bound, in pixels.
- `X_MAX`, 600: inclusive X bound, in pixels.
- `Y_MIN`, 0: inclusive Y bound, in pixels.
- `Y_MAX`, 440: inclusive Y bound, in pixels.
- `DWELL_FRAMES`, 15: frames paused at an edge in BOUNCE mode.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `enable` in 1: 0 freezes all motion and counters.
- `restart` in 1: one-cycle pulse; returns the block to reset values.
- `mode` in 2: 00 STOP, 01 WRAP, 10 BOUNCE, 11 treated as STOP.
- `topLeftX` out 11 signed: X position, `posX >>> FRAC_BITS`.
- `topLeftY` out 11 signed: Y position, `posY >>> FRAC_BITS`.
- `dirX` out 1: 1 when current X velocity is negative.
- `dirY` out 1: 1 when current Y velocity is negative.
- `edgeHit` out 1: one-cycle pulse on any boundary event.
- `halted` out 1: high in HALTED state.

## Operation
- State: `posX`, `posY` (32-bit signed fixed point); `velX`, `velY` (32-bit signed); FSM; dwell counter.
- Fixed-point bounds: minF = MIN << FRAC_BITS, maxF = MAX << FRAC_BITS, per axis.
- Reset and restart load the same values:
  - pos = INITIAL << FRAC_BITS; vel = *_SPEED; state MOVING; counter 0.
  - `edgeHit` = 0; `halted` = 0; `dir*` reflect the speed signs.
- FSM states: MOVING, DWELL, HALTED.
- MOVING, on `startOfFrame && enable`: next = pos + vel per axis. An axis is over if next > maxF and under if next < minF.
- No axis over or under: pos = next.
- Any axis over or under, with `mode` sampled that cycle, `edgeHit` = 1:
  - STOP/11: offending axes clamp to maxF/minF. Other axes take next. Go to HALTED.
  - WRAP, over: pos = minF + (next − maxF). WRAP, under: pos = maxF − (minF − next). Stay in MOVING.
  - BOUNCE: offending axes clamp, and their flip flags are set. Other axes take next.
    - DWELL_FRAMES = 0: negate flagged velocities immediately; stay in MOVING.
    - Otherwise load counter = DWELL_FRAMES and go to DWELL.
- DWELL, on `startOfFrame && enable`:
  - Counter ≠ 0: decrement; no motion.
  - Counter = 0: negate flagged velocities, clear the flags, go to MOVING. No motion on this frame.
- HALTED: no motion. Left only by `reset` or `restart`.
- `enable` = 0: `startOfFrame` is ignored entirely.
- Priority: `reset` > `restart` > frame update. `restart` coinciding with `startOfFrame` applies the restart only.
- Legal parameters: MIN < MAX; INITIAL within bounds; |SPEED| < (MAX − MIN) << FRAC_BITS. Behaviour outside these is undefined.

## Timing
- All state updates on the rising `clk` edge, registered.
- Position is visible on `topLeft*` one cycle after the `startOfFrame` cycle.
- `edgeHit` is high for exactly that same one cycle.
- `topLeft*`, `dir*` and `halted` are combinational from registers; no further latency.
- Reset asserted mid-DWELL or in HALTED returns to MOVING at initial values in the next cycle.

## Structure
- Package `mover_pkg` holds:
  - `mode_t` enum (STOP, WRAP, BOUNCE).
  - `mover_state_t` enum (MOVING, DWELL, HALTED).
  - `FRAC_BITS_DEFAULT`.
- Sub-module `axis_step`: combinational, one axis. Takes pos, vel, minF, maxF, mode. Outputs next pos, over, under and flip. Instantiated twice.
- Top level holds the FSM, dwell counter, registers and output shift.

## Test plan
- Defaults, `enable` = 1, mode BOUNCE, one frame → `topLeftX` 280 (17950 >>> 6). After 3 frames → 281; after 64 frames → 310. `topLeftY` stays 100.
- X_SPEED 64, X_MAX 282, BOUNCE → X reads 281, then 282; third frame `edgeHit` pulses and X stays 282. Then 15 frames with no motion. The next frame sets `dirX` = 1 with no motion, and the following frame gives 281.
- X_SPEED 64, INITIAL_X 300, X_MAX 300, X_MIN 0, WRAP → one frame gives `topLeftX` 1, `edgeHit` pulse, still MOVING.
- Same setup in STOP → X clamps at 300 and `halted` = 1. 10 further frames leave X unchanged. A `restart` pulse gives X = 300, `halted` = 0.
- `enable` = 0 for 20 frames → no change.
- `restart` and `startOfFrame` in the same cycle after motion → X = 280 exactly; no step that frame.
- `reset` asserted mid-DWELL → next cycle shows X = 280, `dirX` = 0, state MOVING, and the next frame moves normally.
